mux_serializer: RTL and testbench

Parallel-to-serial front end for the 8:1 multiplexer tree. It accepts an 8-bit word over a valid/ready handshake and holds it on the mux data bus. It steps the 3-bit select through all eight positions and presents the selected bit as a serial stream with its own valid/ready handshake. It is the stage that drives `d` and `x` of `MUX_81`, which it instantiates, and it feeds any bit-serial consumer downstream.

---
 rtl/mux_serializer_pkg.sv | 10 +
 rtl/mux_serializer_if.sv | 26 ++
 rtl/MUX_81.sv | 8 +
 rtl/mux_serializer.sv | 82 ++++++++
 tb/tb_mux_serializer.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/mux_serializer_pkg.sv
// Shared widths and FSM state type for the mux_serializer front end.
package mux_serializer_pkg;
    localparam int SER_W     = 8;
    localparam int SER_SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;
endpackage

// File: rtl/mux_serializer_if.sv
// Parallel-in and serial-out handshake bundle, plus the select/busy debug taps.
// Handshake rule for both sides: a transfer happens on a rising edge where
// valid and ready are both high; valid never drops until its transfer.
interface mux_serializer_if;
    import mux_serializer_pkg::*;

    logic [SER_W-1:0]     in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 ser_bit;
    logic                 ser_valid;
    logic                 ser_ready;
    logic                 ser_last;
    logic [SER_SEL_W-1:0] sel;
    logic                 busy;

    modport master (
        output in_data, in_valid, ser_ready,
        input  in_ready, ser_bit, ser_valid, ser_last, sel, busy
    );

    modport slave (
        input  in_data, in_valid, ser_ready,
        output in_ready, ser_bit, ser_valid, ser_last, sel, busy
    );
endinterface

// File: rtl/MUX_81.sv
// Existing 8:1 multiplexer: y = d[x].
module MUX_81 (
    input  logic [7:0] d,
    input  logic [2:0] x,
    output logic       y
);
    assign y = d[x];
endmodule

// File: rtl/mux_serializer.sv
// Holds an accepted 8-bit word on the MUX_81 data bus and walks its select
// through all eight positions, emitting one bit per accepted serial beat.
module mux_serializer
    import mux_serializer_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_serializer_if.slave bus
);
    localparam logic [SER_SEL_W-1:0] SEL_START = LSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [SER_SEL_W-1:0] SEL_END   = LSB_FIRST ? 3'd7 : 3'd0;

    ser_state_t           state_q, state_d;
    logic [SER_W-1:0]     word_q, word_d;
    logic [SER_SEL_W-1:0] sel_q, sel_d;
    logic                 in_shift;
    logic                 last_bit;
    logic                 mux_y;

    MUX_81 u_mux (
        .d (word_q),
        .x (sel_q),
        .y (mux_y)
    );

    assign in_shift = (state_q == SHIFT);
    assign last_bit = in_shift && (sel_q == SEL_END);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    word_d  = bus.in_data;
                    sel_d   = SEL_START;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.ser_ready) begin
                    if (!last_bit) begin
                        sel_d = LSB_FIRST ? sel_q + 3'd1 : sel_q - 3'd1;
                    end else if (bus.in_valid) begin
                        // Reload on the last beat so words stream without a bubble.
                        word_d = bus.in_data;
                        sel_d  = SEL_START;
                    end else begin
                        sel_d   = SEL_START;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = SEL_START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            sel_q   <= SEL_START;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.in_ready  = !in_shift || (last_bit && bus.ser_ready);
    assign bus.ser_valid = in_shift;
    assign bus.busy      = in_shift;
    assign bus.ser_last  = last_bit;
    assign bus.ser_bit   = in_shift & mux_y;
    assign bus.sel       = sel_q;
endmodule

// File: tb/tb_mux_serializer.sv
// Directed, table-driven bench for mux_serializer (LSB-first and MSB-first builds).
module tb_mux_serializer;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mux_serializer_if bus ();
  mux_serializer_if bus_m ();

  mux_serializer #(.LSB_FIRST(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  mux_serializer #(.LSB_FIRST(1'b0)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m.slave));

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       rdy;
    logic       ev;
    logic       eb;
    logic       el;
    logic [2:0] es;
    logic       eir;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(input logic iv, input logic [7:0] d, input logic rdy,
                            input logic ev, input logic eb, input logic el,
                            input logic [2:0] es, input logic eir);
    vec_t t;
    t.iv = iv; t.d = d; t.rdy = rdy;
    t.ev = ev; t.eb = eb; t.el = el; t.es = es; t.eir = eir;
    tbl.push_back(t);
  endfunction

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // driver: inputs set on the falling edge, outputs compared 1 ns later
  task automatic apply(input vec_t t, input bit msb, input string tag);
    logic ov, ob, ol, oir;
    logic [2:0] os;
    @(negedge clk);
    if (msb) begin
      bus_m.in_valid = t.iv; bus_m.in_data = t.d; bus_m.ser_ready = t.rdy;
    end else begin
      bus.in_valid = t.iv; bus.in_data = t.d; bus.ser_ready = t.rdy;
    end
    #1;
    ov  = msb ? bus_m.ser_valid : bus.ser_valid;
    ob  = msb ? bus_m.ser_bit   : bus.ser_bit;
    ol  = msb ? bus_m.ser_last  : bus.ser_last;
    oir = msb ? bus_m.in_ready  : bus.in_ready;
    os  = msb ? bus_m.sel       : bus.sel;
    chk({tag, "_valid"}, {7'd0, ov}, {7'd0, t.ev});
    chk({tag, "_bit"}, {7'd0, ob}, {7'd0, t.eb});
    chk({tag, "_last"}, {7'd0, ol}, {7'd0, t.el});
    chk({tag, "_in_ready"}, {7'd0, oir}, {7'd0, t.eir});
    chk({tag, "_sel"}, {5'd0, os}, {5'd0, t.es});
    chk({tag, "_busy"}, {7'd0, msb ? bus_m.busy : bus.busy}, {7'd0, t.ev});
  endtask

  logic [7:0] pat_a5;
  logic [7:0] pat_3c;
  logic [7:0] pat_01;
  vec_t       t;

  initial begin
    checks = 0;
    failures = 0;
    // cycle-order bit sequences, first bit in [7]
    pat_a5 = 8'b1010_0101;
    pat_3c = 8'b0011_1100;
    pat_01 = 8'b1000_0000;

    bus.in_valid = 1'b0; bus.in_data = '0; bus.ser_ready = 1'b0;
    bus_m.in_valid = 1'b0; bus_m.in_data = '0; bus_m.ser_ready = 1'b0;

    // reset held with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 8'($urandom_range(0, 255));
      bus.ser_ready = 1'($urandom_range(0, 1));
      bus_m.in_valid  = 1'($urandom_range(0, 1));
      bus_m.in_data   = 8'($urandom_range(0, 255));
      bus_m.ser_ready = 1'($urandom_range(0, 1));
      #1;
      chk("rst_in_ready", {7'd0, bus.in_ready}, 8'd1);
      chk("rst_valid", {7'd0, bus.ser_valid}, 8'd0);
      chk("rst_bit", {7'd0, bus.ser_bit}, 8'd0);
      chk("rst_last", {7'd0, bus.ser_last}, 8'd0);
      chk("rst_busy", {7'd0, bus.busy}, 8'd0);
      chk("rst_sel", {5'd0, bus.sel}, 8'd0);
      chk("rst_m_sel", {5'd0, bus_m.sel}, 8'd7);
      chk("rst_m_valid", {7'd0, bus_m.ser_valid}, 8'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.ser_ready = 1'b1;
    bus_m.in_valid = 1'b0; bus_m.ser_ready = 1'b1;
    rst_n = 1'b1;

    // single word 0xA5
    v(1, 8'hA5, 1, 0, 0, 0, 3'd0, 1);
    for (int i = 0; i < 8; i++) v(0, 8'h00, 1, 1, pat_a5[7-i], i == 7, 3'(i), i == 7);
    v(0, 8'h00, 1, 0, 0, 0, 3'd0, 1);
    // back-to-back 0xA5 then 0x3C; 0xFF during the second word must be ignored
    v(1, 8'hA5, 1, 0, 0, 0, 3'd0, 1);
    for (int i = 0; i < 8; i++) v(1, 8'h3C, 1, 1, pat_a5[7-i], i == 7, 3'(i), i == 7);
    for (int i = 0; i < 8; i++) v(0, 8'hFF, 1, 1, pat_3c[7-i], i == 7, 3'(i), i == 7);
    v(0, 8'h00, 1, 0, 0, 0, 3'd0, 1);
    // backpressure: three stalled cycles at sel=2
    v(1, 8'hA5, 1, 0, 0, 0, 3'd0, 1);
    v(0, 8'h00, 1, 1, 1, 0, 3'd0, 0);
    v(0, 8'h00, 1, 1, 0, 0, 3'd1, 0);
    for (int k = 0; k < 3; k++) v(0, 8'h00, 0, 1, 1, 0, 3'd2, 0);
    for (int i = 2; i < 8; i++) v(0, 8'h00, 1, 1, pat_a5[7-i], i == 7, 3'(i), i == 7);
    v(0, 8'h00, 1, 0, 0, 0, 3'd0, 1);
    // stall on the last bit: in_ready must stay low, pending word not taken
    v(1, 8'h01, 1, 0, 0, 0, 3'd0, 1);
    for (int i = 0; i < 7; i++) v(0, 8'h00, 1, 1, pat_01[7-i], 0, 3'(i), 0);
    v(1, 8'h55, 0, 1, 0, 1, 3'd7, 0);
    v(0, 8'h55, 1, 1, 0, 1, 3'd7, 1);
    v(0, 8'h00, 1, 0, 0, 0, 3'd0, 1);

    foreach (tbl[i]) apply(tbl[i], 1'b0, $sformatf("v%0d", i));

    // MSB-first: 0x80 gives a 1 then seven 0s, sel 7 down to 0
    t = '{iv: 1, d: 8'h80, rdy: 1, ev: 0, eb: 0, el: 0, es: 3'd7, eir: 1};
    apply(t, 1'b1, "msb_idle");
    for (int i = 0; i < 8; i++) begin
      t = '{iv: 0, d: 8'h00, rdy: 1, ev: 1, eb: (i == 0), el: (i == 7), es: 3'(7 - i), eir: (i == 7)};
      apply(t, 1'b1, $sformatf("msb%0d", i));
    end
    t = '{iv: 0, d: 8'h00, rdy: 1, ev: 0, eb: 0, el: 0, es: 3'd7, eir: 1};
    apply(t, 1'b1, "msb_done");

    // reset in the middle of 0xFF at bit 4
    t = '{iv: 1, d: 8'hFF, rdy: 1, ev: 0, eb: 0, el: 0, es: 3'd0, eir: 1};
    apply(t, 1'b0, "mid_start");
    for (int i = 0; i < 5; i++) begin
      t = '{iv: 0, d: 8'h00, rdy: 1, ev: 1, eb: 1, el: 0, es: 3'(i), eir: 0};
      apply(t, 1'b0, $sformatf("mid%0d", i));
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {7'd0, bus.ser_valid}, 8'd0);
    chk("mid_rst_bit", {7'd0, bus.ser_bit}, 8'd0);
    chk("mid_rst_sel", {5'd0, bus.sel}, 8'd0);
    chk("mid_rst_in_ready", {7'd0, bus.in_ready}, 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    t = '{iv: 1, d: 8'h01, rdy: 1, ev: 0, eb: 0, el: 0, es: 3'd0, eir: 1};
    apply(t, 1'b0, "post_start");
    for (int i = 0; i < 8; i++) begin
      t = '{iv: 0, d: 8'h00, rdy: 1, ev: 1, eb: pat_01[7-i], el: (i == 7), es: 3'(i), eir: (i == 7)};
      apply(t, 1'b0, $sformatf("post%0d", i));
    end
    t = '{iv: 0, d: 8'h00, rdy: 1, ev: 0, eb: 0, el: 0, es: 3'd0, eir: 1};
    apply(t, 1'b0, "post_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
